mix_columns_seq: RTL and testbench

Column-serial AES MixColumns stage with a valid/ready handshake on both sides. It consumes the 128-bit state produced by the ShiftRows stage and transforms one 32-bit column per clock. Four arithmetic cycles complete one block. A bypass input supports the final AES round, which skips MixColumns. The OP parameter selects the forward matrix (encrypt) or the inverse matrix (decrypt).

---
 rtl/mix_columns_seq.sv | 123 ++++++++++++
 tb/tb_mix_columns_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mix_columns_seq: column-serial AES MixColumns, one 32-bit column/cycle.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module mix_columns_seq #(
    parameter int OP = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] s_i,
    input  logic         bypass_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] s_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] s_q, s_d;
    logic [6:0]   col_lsb;
    logic [31:0]  col_in;
    logic [31:0]  col_out;
    logic         accept;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Column 0 sits in the most-significant word, so the bit offset is (3-col)*32.
    assign col_lsb = {~col_q, 5'b0_0000};
    assign col_in  = s_q[col_lsb +: 32];

    generate
        if (OP == 1) begin : g_fwd
            logic [3:0][7:0] a;
            logic [3:0][7:0] x2;
            for (genvar i = 0; i < 4; i++) begin : g_byte
                assign a[i]  = col_in[31-8*i -: 8];
                assign x2[i] = xtime(a[i]);
            end
            assign col_out = {x2[0] ^ x2[1] ^ a[1] ^ a[2] ^ a[3],
                              a[0] ^ x2[1] ^ x2[2] ^ a[2] ^ a[3],
                              a[0] ^ a[1] ^ x2[2] ^ x2[3] ^ a[3],
                              x2[0] ^ a[0] ^ a[1] ^ a[2] ^ x2[3]};
        end else begin : g_inv
            logic [3:0][7:0] a;
            logic [3:0][7:0] m9, mb, md, me;
            for (genvar i = 0; i < 4; i++) begin : g_byte
                logic [7:0] x2, x4, x8;
                assign a[i]  = col_in[31-8*i -: 8];
                assign x2    = xtime(a[i]);
                assign x4    = xtime(x2);
                assign x8    = xtime(x4);
                assign m9[i] = x8 ^ a[i];
                assign mb[i] = x8 ^ x2 ^ a[i];
                assign md[i] = x8 ^ x4 ^ a[i];
                assign me[i] = x8 ^ x4 ^ x2;
            end
            assign col_out = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                              m9[0] ^ me[1] ^ mb[2] ^ md[3],
                              md[0] ^ m9[1] ^ me[2] ^ mb[3],
                              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        s_d        = s_q;
        in_ready_o = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
        accept     = in_valid_i && in_ready_o;
        case (state_q)
            CALC: begin
                s_d[col_lsb +: 32] = col_out;
                col_d              = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            IDLE: ;
            default: state_d = IDLE;
        endcase
        // A new block may be loaded from IDLE or in the same cycle DONE hands off.
        if (accept) begin
            s_d     = s_i;
            col_d   = 2'd0;
            state_d = bypass_i ? DONE : CALC;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            s_q     <= 128'h0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            s_q     <= s_d;
        end
    end

    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign s_o         = s_q;

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mix_columns_seq: checks forward (OP=1) and inverse (OP=0) instances.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_mix_columns_seq;

    logic         clk, rst_n, in_valid, bypass, out_ready;
    logic [127:0] s_in;
    logic         in_ready_f, out_valid_f, busy_f;
    logic         in_ready_i, out_valid_i, busy_i;
    logic [127:0] s_out_f, s_out_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc, val_cyc;

    mix_columns_seq #(.OP(1)) u_fwd (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_f),
        .s_i(s_in), .bypass_i(bypass), .out_valid_o(out_valid_f),
        .out_ready_i(out_ready), .s_o(s_out_f), .busy_o(busy_f)
    );

    mix_columns_seq #(.OP(0)) u_inv (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_i),
        .s_i(s_in), .bypass_i(bypass), .out_valid_o(out_valid_i),
        .out_ready_i(out_ready), .s_o(s_out_i), .busy_o(busy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: carry-less polynomial product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] mix_model(input logic [127:0] s, input bit inv);
        logic [7:0]   base [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (inv) begin
            base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
        end else begin
            base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(base[(j - row + 4) % 4], s[8*(15-(4*c+j)) +: 8]);
                r[8*(15-(4*c+row)) +: 8] = acc;
            end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_block(input logic [127:0] s, input logic byp);
        int n;
        n = 0;
        in_valid = 1'b1;
        s_in     = s;
        bypass   = byp;
        while (!(in_ready_f && in_ready_i) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 128'(in_ready_f & in_ready_i), 128'd1);
        @(posedge clk);
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, input logic [127:0] ef,
                              input logic [127:0] ei, input int exp_lat);
        int lat;
        lat = 0;
        while (!(out_valid_f && out_valid_i) && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        val_cyc = cyc;
        chk({name, "_lat"}, 128'(lat), 128'(exp_lat));
        chk({name, "_fwd"}, s_out_f, ef);
        chk({name, "_inv"}, s_out_i, ei);
    endtask

    typedef struct {
        logic [127:0] s;
        logic         byp;
        logic [127:0] ef;
        logic [127:0] ei;
    } vec_t;

    localparam logic [127:0] C_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] C_B = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] C_C = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] C_D = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] C_P = 128'h00112233_44556677_8899aabb_ccddeeff;

    vec_t         vt [5];
    logic [127:0] s_r, held_f, held_i;
    logic         b_r;
    int           prev_val;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; s_in = '0; bypass = 1'b0; out_ready = 1'b1;

        vt[0] = '{C_A, 1'b0, C_B, mix_model(C_A, 1'b1)};
        vt[1] = '{C_B, 1'b0, mix_model(C_B, 1'b0), C_A};
        vt[2] = '{C_C, 1'b0, C_D, mix_model(C_C, 1'b1)};
        vt[3] = '{C_D, 1'b0, mix_model(C_D, 1'b0), C_C};
        vt[4] = '{C_P, 1'b1, C_P, C_P};

        #12;
        chk("rst_valid", 128'({out_valid_f, out_valid_i}), 128'd0);
        chk("rst_busy", 128'({busy_f, busy_i}), 128'd0);
        chk("rst_s_fwd", s_out_f, 128'h0);
        chk("rst_s_inv", s_out_i, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_ready", 128'({in_ready_f, in_ready_i}), 128'd3);
        @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            start_block(vt[k].s, vt[k].byp);
            wait_valid($sformatf("vec%0d", k), vt[k].ef, vt[k].ei, vt[k].byp ? 0 : 4);
        end

        // Backpressure then overlapped handoff/acceptance.
        @(negedge clk);
        out_ready = 1'b0;
        start_block(C_C, 1'b0);
        wait_valid("bp_first", C_D, mix_model(C_C, 1'b1), 4);
        held_f = s_out_f;
        held_i = s_out_i;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_fwd", s_out_f, held_f);
            chk("bp_hold_inv", s_out_i, held_i);
            chk("bp_valid", 128'({out_valid_f, out_valid_i}), 128'd3);
            chk("bp_ready", 128'({in_ready_f, in_ready_i}), 128'd0);
        end
        out_ready = 1'b1;
        start_block(C_A, 1'b0);
        chk("handoff", 128'({out_valid_f, out_valid_i, busy_f, busy_i}), 128'b0011);
        wait_valid("bp_second", C_B, mix_model(C_A, 1'b1), 4);

        // Asynchronous reset after column 1 has been written.
        @(negedge clk);
        start_block(C_A, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("mid_busy", 128'({busy_f, busy_i}), 128'd3);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'({out_valid_f, out_valid_i}), 128'd0);
        chk("arst_busy", 128'({busy_f, busy_i}), 128'd0);
        chk("arst_s_fwd", s_out_f, 128'h0);
        chk("arst_s_inv", s_out_i, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("arst_ready", 128'({in_ready_f, in_ready_i}), 128'd3);
        @(negedge clk);
        start_block(C_C, 1'b0);
        wait_valid("post_rst", C_D, mix_model(C_C, 1'b1), 4);

        // Back-to-back random normal blocks: one result every 5 cycles.
        prev_val = 0;
        for (int k = 0; k < 8; k++) begin
            s_r = {$urandom, $urandom, $urandom, $urandom};
            start_block(s_r, 1'b0);
            wait_valid($sformatf("thr%0d", k), mix_model(s_r, 1'b0), mix_model(s_r, 1'b1), 4);
            if (k > 0) chk("thr_spacing", 128'(val_cyc - prev_val), 128'd5);
            prev_val = val_cyc;
        end

        // Random mix of bypass and normal blocks.
        for (int k = 0; k < 6; k++) begin
            s_r = {$urandom, $urandom, $urandom, $urandom};
            b_r = 1'($urandom_range(0, 1));
            start_block(s_r, b_r);
            wait_valid($sformatf("rnd%0d", k), b_r ? s_r : mix_model(s_r, 1'b0),
                       b_r ? s_r : mix_model(s_r, 1'b1), b_r ? 0 : 4);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
